adc_trig_capture: RTL and testbench

//   Triggered acquisition buffer directly downstream of the AD9235 capture stage. Consumes 12-bit

---
 rtl/adc_trig_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_adc_trig_capture.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: triggered circular capture of ADC samples with valid/ready readout (rev 1.0).
// Optional macro CAP_TIMEOUT_EN: a WAIT_TRIG cycle timeout forces an auto-trigger and sets trig_auto.
`default_nettype none

module adc_trig_capture #(
  parameter int DW = 12,
  parameter int AW = 10
`ifdef CAP_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1000000
`endif
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  input  logic          arm,
  input  logic          abort,
  input  logic [DW-1:0] trig_lvl,
  input  logic          trig_fall,
  input  logic [AW-1:0] pre_len,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic          trig_auto
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DUMP = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] pre_len_q, pre_len_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          trig_auto_q, trig_auto_d;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   cnt_inc;
  logic [AW:0]   post_len;
  logic          crossing;
  logic          trig_hit;
  logic          force_trig;

  // cnt_q is the pre count in PRE, the post count in POST and the read index in DUMP.
  assign cnt_inc  = cnt_q + 1'b1;
  assign post_len = DEPTH_C - {1'b0, pre_len_q};
  assign rd_addr  = start_q + cnt_q[AW-1:0];

  assign crossing = trig_fall ? ((prev_q > trig_lvl) && (s_data <= trig_lvl))
                              : ((prev_q < trig_lvl) && (s_data >= trig_lvl));
  assign trig_hit = prev_valid_q && crossing;

`ifdef CAP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if ((state_q != S_WAIT) || abort) begin
      to_cnt_q <= '0;
    end else if (!force_trig) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Saturates and stays asserted until the next sample closes the wait.
  assign force_trig = (to_cnt_q == TW'(TIMEOUT_CYC));
`else
  assign force_trig = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_len_d    = pre_len_q;
    start_d      = start_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    trig_auto_d  = trig_auto_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;

    if (s_valid && !abort && (state_q inside {S_PRE, S_WAIT, S_POST})) begin
      wr_en        = 1'b1;
      wr_ptr_d     = wr_ptr_q + 1'b1;
      prev_d       = s_data;
      prev_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (arm && !abort) begin
          pre_len_d    = pre_len;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
          trig_auto_d  = 1'b0;
          state_d      = (pre_len == '0) ? S_WAIT : S_PRE;
        end
      end
      S_PRE: begin
        if (s_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == {1'b0, pre_len_q}) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (s_valid && (trig_hit || force_trig)) begin
          // The trigger sample is post sample 1; the record starts pre_len before it.
          start_d     = wr_ptr_q - pre_len_q;
          trig_auto_d = force_trig && !trig_hit;
          if (post_len == (AW+1)'(1)) begin
            cnt_d   = '0;
            state_d = S_DUMP;
          end else begin
            cnt_d   = (AW+1)'(1);
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (s_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == post_len) begin
            cnt_d   = '0;
            state_d = S_DUMP;
          end
        end
      end
      S_DUMP: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_q) begin
            state_d = S_IDLE;
          end
        end
        // One-deep read pipeline: refill whenever the output slot is empty or being drained.
        if (!cnt_q[AW] && (!m_valid_q || m_ready)) begin
          rd_en     = 1'b1;
          cnt_d     = cnt_inc;
          m_valid_d = 1'b1;
          m_last_d  = (cnt_q[AW-1:0] == {AW{1'b1}});
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      rd_en     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      pre_len_q    <= '0;
      start_q      <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      trig_auto_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_len_q    <= pre_len_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      trig_auto_q  <= trig_auto_d;
    end
  end

  // Sample RAM: no reset so it maps onto block RAM; the read register holds during stalls.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= s_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign m_data    = m_valid_q ? rd_data_q : '0;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q != S_IDLE);
  assign trig_auto = trig_auto_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_trig_capture.sv
// tb_adc_trig_capture: random and directed records checked by a scoreboard fed from a sample-history model.
`default_nettype none

module tb_adc_trig_capture;
  localparam int DW    = 12;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef CAP_TIMEOUT_EN
  localparam int MAX_WAIT = 20;
`else
  localparam int MAX_WAIT = 1000;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] trig_lvl = '0;
  logic          trig_fall = 1'b0;
  logic [AW-1:0] pre_len = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          busy;
  logic          trig_auto;

  int total = 0;
  int bad = 0;
  int rdy_mode = 0;
  int stim[$];
  logic [DW-1:0] exp_d[$];
  logic          exp_l[$];
  logic [DW-1:0] beat_log[$];

  always #5 clk = ~clk;

  adc_trig_capture #(
    .DW(DW),
    .AW(AW)
`ifdef CAP_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(100)
`endif
  ) dut (
    .sys_clk  (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .arm      (arm),
    .abort    (abort),
    .trig_lvl (trig_lvl),
    .trig_fall(trig_fall),
    .pre_len  (pre_len),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .trig_auto(trig_auto)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, expv);
    end
  endtask

  // Reference: the trigger is the first crossing at or after sample index pre_len (the first sample
  // seen in WAIT_TRIG) that also has a preceding sample since arm.
  function automatic int find_trig(input int pre, input int lvl, input bit fall);
    for (int i = (pre > 0 ? pre : 1); i < stim.size(); i++) begin
      if (!fall && stim[i-1] < lvl && stim[i] >= lvl) return i;
      if (fall && stim[i-1] > lvl && stim[i] <= lvl) return i;
    end
    return -1;
  endfunction

  // Sink readiness pattern, selected by rdy_mode.
  initial begin
    int pat = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        2: begin
          m_ready = (pat == 0);
          pat = (pat == 2) ? 0 : pat + 1;
        end
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks that stalled beats are held.
  initial begin
    logic          hold_chk = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic          held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && hold_chk) begin
        chk("hold_data", m_data, held_d);
        chk("hold_last", m_last, held_l);
      end
      if (rst_n && m_valid && m_ready) begin
        if (exp_d.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got=%0h want=none", m_data);
        end else begin
          chk("beat_data", m_data, exp_d.pop_front());
          chk("beat_last", m_last, exp_l.pop_front());
        end
        beat_log.push_back(m_data);
      end
      hold_chk = rst_n && m_valid && !m_ready;
      held_d   = m_data;
      held_l   = m_last;
    end
  end

  task automatic do_arm(input int pre, input int lvl, input bit fall);
    pre_len   = AW'(pre);
    trig_lvl  = DW'(lvl);
    trig_fall = fall;
    arm       = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  // One sample, then one or two idle cycles (never back-to-back strobes).
  task automatic put(input logic [DW-1:0] v);
    s_data  = v;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat ($urandom_range(1, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((busy || exp_d.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 32'(n < 3000), 1);
    exp_d.delete();
    exp_l.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_rec(input int pre, input int lvl, input bit fall, input string nm);
    int t;
    t = find_trig(pre, lvl, fall);
    if (t < 0 || t - pre + DEPTH > stim.size()) begin
      total++;
      bad++;
      $display("FAIL %s: no usable trigger in stimulus", nm);
      return;
    end
    beat_log.delete();
    for (int k = 0; k < DEPTH; k++) begin
      exp_d.push_back(DW'(stim[t-pre+k]));
      exp_l.push_back(k == DEPTH - 1);
    end
    do_arm(pre, lvl, fall);
    foreach (stim[i]) put(DW'(stim[i]));
    wait_done(nm);
    chk({nm, "_beats"}, beat_log.size(), DEPTH);
    chk({nm, "_auto"}, trig_auto, 0);
  endtask

  initial begin
    int seen;
    int t;
    int pre;
    int lvl;
    bit fall;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_trig_auto", trig_auto, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Rising ramp.
    rdy_mode = 0;
    stim.delete();
    for (int i = 0; i < 64; i++) stim.push_back(i);
    run_rec(4, 20, 1'b0, "ramp");
    if (beat_log.size() == DEPTH) begin
      chk("ramp_first", beat_log[0], 16);
      chk("ramp_trig", beat_log[4], 20);
      chk("ramp_lastval", beat_log[15], 31);
    end

`ifndef CAP_TIMEOUT_EN
    // Falling, descending ramp.
    stim.delete();
    for (int i = 100; i >= 0; i--) stim.push_back(i);
    run_rec(4, 50, 1'b1, "fall");
    if (beat_log.size() == DEPTH) begin
      chk("fall_first", beat_log[0], 54);
      chk("fall_trig", beat_log[4], 50);
      chk("fall_lastval", beat_log[15], 39);
    end

    // Long wait in WAIT_TRIG: the RAM wraps several times before the crossing.
    stim.delete();
    for (int i = 0; i < 45; i++) stim.push_back($urandom_range(0, 99));
    for (int i = 100; i < 140; i++) stim.push_back(i);
    run_rec(4, 100, 1'b0, "wrap");
    if (beat_log.size() == DEPTH) begin
      chk("wrap_first", beat_log[0], stim[41]);
      chk("wrap_pre3", beat_log[3], stim[44]);
      chk("wrap_trig", beat_log[4], 100);
    end
`endif

    // pre_len = 0 step.
    stim.delete();
    repeat (5) stim.push_back(0);
    repeat (30) stim.push_back(12'hFFF);
    run_rec(0, 12'h800, 1'b0, "step");
    if (beat_log.size() == DEPTH) chk("step_first", beat_log[0], 12'hFFF);

    // Stalled readout 1,0,0 pattern.
    rdy_mode = 2;
    stim.delete();
    for (int i = 0; i < 64; i++) stim.push_back(i);
    run_rec(4, 20, 1'b0, "stall");
    rdy_mode = 0;

    // Abort mid-POST.
    beat_log.delete();
    do_arm(4, 20, 1'b0);
    for (int i = 0; i < 23; i++) put(DW'(i));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    seen = 0;
    for (int i = 23; i < 45; i++) begin
      put(DW'(i));
      if (m_valid) seen++;
    end
    chk("abort_m_valid", seen, 0);
    chk("abort_beats", beat_log.size(), 0);

    // Asynchronous reset while DUMP is stalled.
    rdy_mode = 3;
    @(posedge clk); #1;
    do_arm(4, 20, 1'b0);
    for (int i = 0; i < 40; i++) put(DW'(i));
    seen = 0;
    while (!m_valid && seen < 200) begin
      @(negedge clk);
      seen++;
    end
    chk("dump_stall_valid", m_valid, 1);
    chk("dump_stall_data", m_data, 16);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_data", m_data, 0);
    chk("arst_m_last", m_last, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;

    // Randomised records.
    for (int it = 0; it < 12; it++) begin
      do begin
        pre  = $urandom_range(0, DEPTH - 1);
        lvl  = $urandom_range(200, 3900);
        fall = 1'($urandom_range(0, 1));
        stim.delete();
        for (int i = 0; i < 60; i++) stim.push_back($urandom_range(0, 4095));
        t = find_trig(pre, lvl, fall);
      end while (t < 0 || t - pre + DEPTH > stim.size() || t - pre > MAX_WAIT);
      rdy_mode = $urandom_range(0, 2);
      run_rec(pre, lvl, fall, "rand");
    end
    rdy_mode = 0;

`ifdef CAP_TIMEOUT_EN
    // Flat input never crosses; the timeout closes the record.
    stim.delete();
    repeat (80) stim.push_back(12'h123);
    beat_log.delete();
    for (int k = 0; k < DEPTH; k++) begin
      exp_d.push_back(12'h123);
      exp_l.push_back(k == DEPTH - 1);
    end
    do_arm(0, 12'h800, 1'b0);
    foreach (stim[i]) put(DW'(stim[i]));
    wait_done("timeout");
    chk("timeout_beats", beat_log.size(), DEPTH);
    chk("timeout_auto", trig_auto, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=hang want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
